// File: rtl/radiant_coinc_trigger_pkg.sv
// rtl/radiant_coinc_trigger_pkg.sv - shared FSM states and default widths for the coincidence trigger
package radiant_coinc_trigger_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2,
    ST_REARM    = 2'd3
  } trig_state_e;

  localparam int DEF_NUM_CH        = 24;
  localparam int DEF_NUM_TRIG      = 4;
  localparam int DEF_ONESHOT_WIDTH = 20;
  localparam int DEF_THRESH_WIDTH  = 5;
  localparam int DEF_HOLDOFF_WIDTH = 16;
  localparam int DEF_COUNT_WIDTH   = 32;

  function automatic logic is_busy(input trig_state_e s);
    return (s == ST_HOLDOFF) || (s == ST_REARM);
  endfunction

endpackage

// File: rtl/radiant_trig_window.sv
// rtl/radiant_trig_window.sv - one per-channel coincidence window counter
module radiant_trig_window
  import radiant_coinc_trigger_pkg::*;
#(
  parameter int WIDTH = DEF_ONESHOT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] window,
  output logic             active
);

  logic [WIDTH-1:0] cnt;

  // A reload while counting restarts the full window, extending it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= window;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/radiant_coinc_trigger.sv
// rtl/radiant_coinc_trigger.sv - N-of-M coincidence trigger engine, NUM_TRIG independent triggers
module radiant_coinc_trigger
  import radiant_coinc_trigger_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int NUM_TRIG      = DEF_NUM_TRIG,
  parameter int ONESHOT_WIDTH = DEF_ONESHOT_WIDTH,
  parameter int THRESH_WIDTH  = DEF_THRESH_WIDTH,
  parameter int HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CH-1:0]                 trig_i,
  input  logic [NUM_TRIG-1:0]               trig_en_i,
  input  logic [NUM_TRIG*NUM_CH-1:0]        trig_maskb_i,
  input  logic [NUM_TRIG*ONESHOT_WIDTH-1:0] trig_window_i,
  input  logic [NUM_TRIG*THRESH_WIDTH-1:0]  trig_thresh_i,
  input  logic [NUM_TRIG*HOLDOFF_WIDTH-1:0] trig_holdoff_i,
  input  logic                              count_clr_i,
  output logic [NUM_TRIG-1:0]               trig_o,
  output logic                              trig_any_o,
  output logic [NUM_TRIG-1:0]               trig_busy_o,
  output logic [NUM_TRIG*COUNT_WIDTH-1:0]   trig_count_o
);

  logic [NUM_TRIG-1:0] fire_d;

  for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
    logic [NUM_CH-1:0]        active;
    logic [THRESH_WIDTH-1:0]  pop;
    logic [THRESH_WIDTH-1:0]  sum_q;
    logic [THRESH_WIDTH-1:0]  thresh;
    logic [HOLDOFF_WIDTH-1:0] holdoff;
    logic [HOLDOFF_WIDTH-1:0] hcnt_q;
    logic [HOLDOFF_WIDTH-1:0] hcnt_d;
    logic [COUNT_WIDTH-1:0]   count_q;
    trig_state_e              state_q;
    trig_state_e              state_d;
    logic                     hit;
    logic                     fire;
    logic                     fire_q;

    assign thresh  = trig_thresh_i[t*THRESH_WIDTH +: THRESH_WIDTH];
    assign holdoff = trig_holdoff_i[t*HOLDOFF_WIDTH +: HOLDOFF_WIDTH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      radiant_trig_window #(.WIDTH(ONESHOT_WIDTH)) u_win (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (!trig_en_i[t] || !trig_maskb_i[t*NUM_CH + c]),
        .load   (trig_i[c]),
        .window (trig_window_i[t*ONESHOT_WIDTH +: ONESHOT_WIDTH]),
        .active (active[c])
      );
    end

    always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pop = pop + THRESH_WIDTH'(active[i]);
      end
    end

    // A zero threshold would otherwise match an empty window.
    assign hit = (thresh != '0) && (sum_q >= thresh);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_DISABLED;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      fire    = 1'b0;
      if (!trig_en_i[t]) begin
        state_d = ST_DISABLED;
      end else begin
        case (state_q)
          ST_DISABLED: state_d = ST_ARMED;
          ST_ARMED: begin
            if (hit) begin
              fire = 1'b1;
              if (holdoff == '0) begin
                state_d = ST_REARM;
              end else begin
                state_d = ST_HOLDOFF;
                hcnt_d  = holdoff;
              end
            end
          end
          ST_HOLDOFF: begin
            if (hcnt_q <= HOLDOFF_WIDTH'(1)) begin
              state_d = ST_REARM;
            end else begin
              hcnt_d = hcnt_q - 1'b1;
            end
          end
          ST_REARM: begin
            if (!hit) state_d = ST_ARMED;
          end
          default: state_d = ST_DISABLED;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hcnt_q  <= '0;
        sum_q   <= '0;
        fire_q  <= 1'b0;
        count_q <= '0;
      end else begin
        hcnt_q <= hcnt_d;
        sum_q  <= pop;
        fire_q <= fire;
        if (count_clr_i) begin
          count_q <= '0;
        end else if (fire && (count_q != '1)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end

    assign fire_d[t]                                   = fire;
    assign trig_o[t]                                   = fire_q;
    assign trig_busy_o[t]                              = is_busy(state_q);
    assign trig_count_o[t*COUNT_WIDTH +: COUNT_WIDTH]  = count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_any_o <= 1'b0;
    end else begin
      trig_any_o <= |fire_d;
    end
  end

endmodule
